// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller.
// Drives the 6-bit stall vector (PC, IF, ID, EX, MEM, WB) and the branch
// flush/redirect. It arbitrates ID load-use stalls, EX level stalls, counted
// multi-cycle EX operations and taken-branch flushes.
// Optional feature macro: STALL_PERF_EN adds a saturating stall-cycle counter
// on stallCycles. When the macro is undefined, stallCycles is tied to zero.
module stall_ctrl #(
    parameter int MULTI_CNT_W  = 6,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallReqID,
    input  logic                   stallReqEX,
    input  logic                   multiStart,
    input  logic [MULTI_CNT_W-1:0] multiCycles,
    input  logic                   branchFlag,
    input  logic [31:0]            branchTarget,
    output logic [5:0]             stall,
    output logic                   flush,
    output logic [31:0]            newPC,
    output logic                   busy,
    output logic [31:0]            stallCycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULTI = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Stalling through EX freezes PC..EX, so MEM receives a bubble.
    // Stalling through ID freezes PC..ID, so EX receives a bubble.
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [MULTI_CNT_W-1:0] r_cnt;
    logic [MULTI_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]             r_fcnt;
    logic [3:0]             w_fcnt_nxt;
    logic                   r_flush;
    logic                   w_flush_nxt;
    logic [31:0]            r_new_pc;
    logic [31:0]            w_new_pc_nxt;
    logic [5:0]             w_stall;
    logic                   w_multi_go;
    logic                   w_multi_long;

    // A zero-length op requests nothing. A one-cycle op is covered entirely
    // by the combinational stall in its start cycle, so only N>=2 needs MULTI.
    assign w_multi_go   = multiStart && (multiCycles != '0);
    assign w_multi_long = multiStart && (multiCycles > MULTI_CNT_W'(1));

    // Stall vector decode from the current state and the live requests.
    always_comb begin
        // NOTE: assign every always_comb output a default first, so that no
        // path leaves the output unassigned and no latch is inferred.
        w_stall = STALL_NONE;
        if (rst) begin
            // NOTE: stall comes straight from the inputs, so it is gated here.
            // Otherwise a request seen during reset would reach the pipeline.
            w_stall = STALL_NONE;
        end else if ((r_state == S_MULTI) ||
                     ((r_state == S_IDLE) && (stallReqEX || w_multi_go))) begin
            w_stall = STALL_EX;
        end else if ((r_state == S_IDLE) && stallReqID) begin
            w_stall = STALL_ID;
        end
    end

    // Next-state logic. In IDLE the priority is branch, then multi-cycle op.
    // MULTI and FLUSH ignore every request input.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_fcnt_nxt   = r_fcnt;
        w_flush_nxt  = r_flush;
        w_new_pc_nxt = r_new_pc;
        case (r_state)
            S_IDLE: begin
                if (branchFlag) begin
                    // A multiStart in the same cycle is dropped on purpose.
                    w_state_nxt  = S_FLUSH;
                    w_flush_nxt  = 1'b1;
                    w_new_pc_nxt = branchTarget;
                    w_fcnt_nxt   = FLUSH_LOAD;
                end else if (w_multi_long) begin
                    // The start cycle already stalls once. MULTI then runs
                    // cnt+1 cycles, so loading N-2 gives exactly N in total.
                    w_state_nxt = S_MULTI;
                    w_cnt_nxt   = multiCycles - MULTI_CNT_W'(2);
                end
            end
            S_MULTI: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - MULTI_CNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (r_fcnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                    w_flush_nxt = 1'b0;
                end else begin
                    w_fcnt_nxt = r_fcnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_flush_nxt = 1'b0;
            end
        endcase
    end

    // State register. Reset aborts any op in progress immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_fcnt   <= 4'd0;
            r_flush  <= 1'b0;
            r_new_pc <= 32'd0;
        end else begin
            // NOTE: use non-blocking assignments for all state, so every
            // register samples its pre-edge value and simulation matches
            // the synthesized hardware.
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_fcnt   <= w_fcnt_nxt;
            r_flush  <= w_flush_nxt;
            r_new_pc <= w_new_pc_nxt;
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of the cycles in which the PC is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
        end else if (w_stall[0] && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stallCycles = r_stall_cycles;
`else
    assign stallCycles = 32'b0;
`endif

    assign stall = w_stall;
    assign flush = r_flush;
    assign newPC = r_new_pc;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl.
// Each test pushes the expected per-cycle outputs onto a scoreboard queue.
// It then drives the stimulus and pops and compares one entry per cycle at
// the falling edge.
// Define STALL_PERF_EN for both the bench and the RTL to check the counter.
module tb_stall_ctrl;

    localparam int W = 6;
    localparam logic [5:0] S_EX   = 6'b001111;
    localparam logic [5:0] S_ID   = 6'b000111;
    localparam logic [5:0] S_NONE = 6'b000000;
`ifdef STALL_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd6;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          stallReqID;
    logic          stallReqEX;
    logic          multiStart;
    logic [W-1:0]  multiCycles;
    logic          branchFlag;
    logic [31:0]   branchTarget;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   newPC;
    logic          busy;
    logic [31:0]   stallCycles;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        busy;
        logic        chk_pc;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    stall_ctrl #(.MULTI_CNT_W(W), .FLUSH_CYCLES(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallReqID   (stallReqID),
        .stallReqEX   (stallReqEX),
        .multiStart   (multiStart),
        .multiCycles  (multiCycles),
        .branchFlag   (branchFlag),
        .branchTarget (branchTarget),
        .stall        (stall),
        .flush        (flush),
        .newPC        (newPC),
        .busy         (busy),
        .stallCycles  (stallCycles)
    );

    task automatic push(input logic [5:0] s, input logic f, input logic b,
                        input logic chk, input logic [31:0] pc);
        exp_t e;
        e.stall  = s;
        e.flush  = f;
        e.busy   = b;
        e.chk_pc = chk;
        e.pc     = pc;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        stallReqID   = 1'b0;
        stallReqEX   = 1'b0;
        multiStart   = 1'b0;
        multiCycles  = '0;
        branchFlag   = 1'b0;
        branchTarget = 32'd0;
    endtask

    // Reset with live requests: every output must stay quiet.
    task automatic test_reset();
        exp_t e;
        rst          = 1'b1;
        clear_inputs();
        stallReqEX   = 1'b1;
        multiStart   = 1'b1;
        multiCycles  = W'(5);
        push(S_NONE, 1'b0, 1'b0, 1'b1, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if ({stall, flush, busy} !== {e.stall, e.flush, e.busy}) begin
            n_errors++;
            $display("FAIL reset: got stall=%b flush=%b busy=%b want stall=%b flush=%b busy=%b",
                     stall, flush, busy, e.stall, e.flush, e.busy);
        end
        n_checks++;
        if (newPC !== e.pc) begin
            n_errors++;
            $display("FAIL reset_newpc: got %h want %h", newPC, e.pc);
        end
        n_checks++;
        if (stallCycles !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_perf: got %0d want 0", stallCycles);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
    endtask

    // One-cycle load-use request.
    task automatic test_load_use();
        exp_t e;
        push(S_ID,   1'b0, 1'b0, 1'b0, 32'd0);
        push(S_NONE, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int c = 0; sb.size() != 0; c++) begin
            stallReqID = (c == 0);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({stall, flush, busy} !== {e.stall, e.flush, e.busy}) begin
                n_errors++;
                $display("FAIL load_use c%0d: got stall=%b flush=%b busy=%b want stall=%b flush=%b busy=%b",
                         c, stall, flush, busy, e.stall, e.flush, e.busy);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    // Counted multi-cycle op of n cycles. A branch and a load-use request
    // are injected mid-op and must both be ignored.
    task automatic test_multi(input int n, input logic [31:0] pc_now);
        exp_t e;
        for (int c = 0; c < n + 2; c++)
            push((c < n) ? S_EX : S_NONE, 1'b0, (c >= 1) && (c < n), 1'b1, pc_now);
        for (int c = 0; sb.size() != 0; c++) begin
            multiStart   = (c == 0);
            multiCycles  = (c == 0) ? W'(n) : W'(0);
            branchFlag   = (c == 1) && (n >= 2);
            branchTarget = 32'hDEAD_BEEF;
            stallReqID   = (c == 1) && (n >= 2);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({stall, flush, busy} !== {e.stall, e.flush, e.busy}) begin
                n_errors++;
                $display("FAIL multi%0d c%0d: got stall=%b flush=%b busy=%b want stall=%b flush=%b busy=%b",
                         n, c, stall, flush, busy, e.stall, e.flush, e.busy);
            end
            n_checks++;
            if (newPC !== e.pc) begin
                n_errors++;
                $display("FAIL multi%0d_newpc c%0d: got %h want %h", n, c, newPC, e.pc);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    // Counter value after the load-use stall plus the 5-cycle op.
    task automatic test_perf();
        n_checks++;
        if (stallCycles !== PERF_EXP) begin
            n_errors++;
            $display("FAIL perf: got %0d want %0d", stallCycles, PERF_EXP);
        end
    endtask

    // Taken branch. Without with_multi: stallReqID in the branch cycle, then
    // stallReqEX during FLUSH. With with_multi: a same-cycle multiStart that
    // must be dropped.
    task automatic test_branch(input logic [31:0] tgt, input logic with_multi);
        exp_t e;
        if (with_multi) begin
            push(S_EX,   1'b0, 1'b0, 1'b0, 32'd0);
            push(S_NONE, 1'b1, 1'b1, 1'b1, tgt);
            push(S_NONE, 1'b0, 1'b0, 1'b1, tgt);
            push(S_NONE, 1'b0, 1'b0, 1'b1, tgt);
        end else begin
            push(S_ID,   1'b0, 1'b0, 1'b0, 32'd0);
            push(S_NONE, 1'b1, 1'b1, 1'b1, tgt);
            push(S_EX,   1'b0, 1'b0, 1'b1, tgt);
            push(S_NONE, 1'b0, 1'b0, 1'b1, tgt);
        end
        for (int c = 0; sb.size() != 0; c++) begin
            clear_inputs();
            if (c == 0) begin
                branchFlag   = 1'b1;
                branchTarget = tgt;
                stallReqID   = !with_multi;
                multiStart   = with_multi;
                multiCycles  = with_multi ? W'(4) : W'(0);
            end else if ((c == 1 || c == 2) && !with_multi) begin
                stallReqEX = 1'b1;
                stallReqID = 1'b1;
            end
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({stall, flush, busy} !== {e.stall, e.flush, e.busy}) begin
                n_errors++;
                $display("FAIL branch_%h c%0d: got stall=%b flush=%b busy=%b want stall=%b flush=%b busy=%b",
                         tgt, c, stall, flush, busy, e.stall, e.flush, e.busy);
            end
            if (e.chk_pc) begin
                n_checks++;
                if (newPC !== e.pc) begin
                    n_errors++;
                    $display("FAIL branch_newpc c%0d: got %h want %h", c, newPC, e.pc);
                end
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    // Reset pulsed in the third cycle of a 10-cycle op.
    task automatic test_abort();
        exp_t e;
        push(S_EX,   1'b0, 1'b0, 1'b0, 32'd0);
        push(S_EX,   1'b0, 1'b1, 1'b0, 32'd0);
        push(S_EX,   1'b0, 1'b1, 1'b0, 32'd0);
        push(S_NONE, 1'b0, 1'b0, 1'b1, 32'd0);
        push(S_NONE, 1'b0, 1'b0, 1'b1, 32'd0);
        push(S_NONE, 1'b0, 1'b0, 1'b1, 32'd0);
        for (int c = 0; sb.size() != 0; c++) begin
            multiStart  = (c == 0);
            multiCycles = (c == 0) ? W'(10) : W'(0);
            if (c == 3) begin
                rst = 1'b1;
                #1;
            end else begin
                @(negedge clk);
            end
            e = sb.pop_front();
            n_checks++;
            if ({stall, flush, busy} !== {e.stall, e.flush, e.busy}) begin
                n_errors++;
                $display("FAIL abort c%0d: got stall=%b flush=%b busy=%b want stall=%b flush=%b busy=%b",
                         c, stall, flush, busy, e.stall, e.flush, e.busy);
            end
            if (e.chk_pc) begin
                n_checks++;
                if (newPC !== e.pc) begin
                    n_errors++;
                    $display("FAIL abort_newpc c%0d: got %h want %h", c, newPC, e.pc);
                end
            end
            if (c == 3) begin
                #1;
                rst = 1'b0;
            end
            if (c == 2) begin
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_multi(5, 32'd0);
        test_perf();
        test_multi(1, 32'd0);
        test_multi(0, 32'd0);
        test_multi(63, 32'd0);
        test_branch(32'h0000_0100, 1'b0);
        test_branch(32'h0000_0200, 1'b1);
        test_abort();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
